// File: rtl/vec_load_streamer_pkg.sv
// Shared types and constants for the vector-load streamer.
//   VEC_LANES / WORD_W : shape of one memory read vector (16 x 16 bit)
//   IMAGE_BYTES        : default image size used for out-of-image lane masking
//   vec_t              : packed vector, lane 0 in the low word
//   stream_state_t     : sequencer states
package vec_mem_pkg;
  localparam int unsigned VEC_LANES     = 16;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned IMG_W_DEFAULT = 96;
  localparam int unsigned IMG_H_DEFAULT = 96;
  localparam int unsigned IMAGE_BYTES   = IMG_W_DEFAULT * IMG_H_DEFAULT;

  typedef logic [VEC_LANES-1:0][WORD_W-1:0] vec_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} stream_state_t;
endpackage

// File: rtl/vec_load_streamer_if.sv
// Bundle of the streamer's command, memory and vector-output signals.
//   start/base_addr/num_vec : burst request from the CPU datapath
//   mem_addr/mem_rd         : data-memory address and combinational read vector
//   vec_*                   : valid/ready delivery to the vector register file
//   busy/done               : burst status
// slave  = streamer side, master = CPU/memory/consumer side.
interface vec_load_streamer_if
  import vec_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       num_vec;
  logic [ADDR_W-1:0] mem_addr;
  vec_t              mem_rd;
  vec_t              vec_out;
  logic              vec_valid;
  logic              vec_ready;
  logic              vec_last;
  logic [15:0]       vec_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, num_vec, mem_rd, vec_ready,
    input  mem_addr, vec_out, vec_valid, vec_last, vec_idx, busy, done
  );

  modport slave (
    input  start, base_addr, num_vec, mem_rd, vec_ready,
    output mem_addr, vec_out, vec_valid, vec_last, vec_idx, busy, done
  );
endinterface

// File: rtl/vec_load_streamer_lane_mask.sv
// Combinational lane masking of one memory read vector.
//   addr_i   : byte address of lane 0
//   rd_i     : raw read vector from the data memory
//   masked_o : lanes >= LANES and lanes past the end of the image forced to 0
module vec_lane_mask
  import vec_mem_pkg::*;
#(
  parameter int unsigned LANES     = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned IMG_BYTES = IMAGE_BYTES
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  vec_t              rd_i,
  output vec_t              masked_o
);
  always_comb begin
    masked_o = '0;
    for (int unsigned i = 0; i < VEC_LANES; i++) begin
      // One extra address bit so a lane near 2^ADDR_W cannot wrap back into the image.
      if ((i < LANES) &&
          (({1'b0, addr_i} + (ADDR_W+1)'(i)) < (ADDR_W+1)'(IMG_BYTES))) begin
        masked_o[i] = rd_i[i];
      end
    end
  end
endmodule

// File: rtl/vec_load_streamer.sv
// Vector-load sequencer and capture stage around the image data memory.
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset
//   bus   : request, memory address/read data, vector valid/ready output and status
// Walks the image LANES bytes per vector, registers the masked read vector and
// hands it to the register file with back-pressure; done pulses once per burst.
module vec_load_streamer
  import vec_mem_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = IMG_W_DEFAULT,
  parameter int unsigned IMAGE_HEIGHT = IMG_H_DEFAULT,
  parameter int unsigned LANES        = 8,
  parameter int unsigned ADDR_W       = 16
) (
  input logic               CLK,
  input logic               RST_N,
  vec_load_streamer_if.slave bus
);
  stream_state_t     state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [15:0]       remaining_q;
  logic [15:0]       fetch_idx_q;
  logic [15:0]       idx_q;
  vec_t              vec_q;
  vec_t              masked;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              cap;

  vec_lane_mask #(
    .LANES    (LANES),
    .ADDR_W   (ADDR_W),
    .IMG_BYTES(IMAGE_WIDTH * IMAGE_HEIGHT)
  ) u_mask (
    .addr_i  (mem_addr_q),
    .rd_i    (bus.mem_rd),
    .masked_o(masked)
  );

  // Output register may be refilled when empty or when drained this same edge.
  assign cap        = !valid_q || bus.vec_ready;
  assign mem_addr_d = mem_addr_q + ADDR_W'(LANES);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      fetch_idx_q <= '0;
      idx_q       <= '0;
      vec_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_vec != '0) begin
              mem_addr_q  <= bus.base_addr;
              remaining_q <= bus.num_vec;
              fetch_idx_q <= '0;
              busy_q      <= 1'b1;
              state_q     <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        FETCH: begin
          if (cap) begin
            vec_q       <= masked;
            valid_q     <= 1'b1;
            idx_q       <= fetch_idx_q;
            last_q      <= (remaining_q == 16'd1);
            mem_addr_q  <= mem_addr_d;
            fetch_idx_q <= fetch_idx_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (valid_q && bus.vec_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.vec_out   = vec_q;
  assign bus.vec_valid = valid_q;
  assign bus.vec_last  = last_q;
  assign bus.vec_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_vec_load_streamer.sv
// Self-checking bench for vec_load_streamer: directed bursts from the test plan
// plus randomized bursts against a queue-based reference model.
module tb_vec_load_streamer;
  import vec_mem_pkg::*;

  localparam int unsigned LANES     = 8;
  localparam int unsigned IMG_BYTES = 96 * 96;

  typedef struct {
    vec_t        v;
    logic [15:0] idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec_load_streamer_if #(.ADDR_W(16)) bus ();

  vec_load_streamer #(
    .IMAGE_WIDTH (96),
    .IMAGE_HEIGHT(96),
    .LANES       (8),
    .ADDR_W      (16)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [0:65535];

  always_comb begin
    bus.mem_rd = '0;
    for (int i = 0; i < 16; i++) bus.mem_rd[i] = {8'h00, mem[bus.mem_addr + 16'(i)]};
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected vector straight from the lane rules: LANES bytes from addr, zero past the image.
  function automatic vec_t model_vec(input int unsigned addr);
    vec_t v;
    v = '0;
    for (int unsigned i = 0; i < LANES; i++)
      if (addr + i < IMG_BYTES) v[i] = {8'h00, mem[16'(addr + i)]};
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  bus.mem_addr,  0);
    chk({tag, "_vec"},   bus.vec_out,   0);
    chk({tag, "_valid"}, bus.vec_valid, 0);
    chk({tag, "_last"},  bus.vec_last,  0);
    chk({tag, "_idx"},   bus.vec_idx,   0);
    chk({tag, "_busy"},  bus.busy,      0);
    chk({tag, "_done"},  bus.done,      0);
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready low for 4 cycles then high.
  // ghost_at >= 0 pulses an ignored start (base 64) at that cycle of the burst.
  task automatic run_burst(input int unsigned base, input int unsigned n, input int mode,
                           input int ghost_at);
    exp_t        exp_q[$];
    exp_t        e;
    int unsigned popped;
    int          last_xfer;
    bit          got_done;
    bit          prev_hold;
    logic        rdy;
    vec_t        pv;
    logic [15:0] pidx;
    logic        plast;
    logic [15:0] paddr;
    popped    = 0;
    last_xfer = -100;
    got_done  = 0;
    prev_hold = 0;
    pv = '0; pidx = '0; plast = 1'b0; paddr = '0;
    for (int unsigned j = 0; j < n; j++) begin
      e.v    = model_vec((base + LANES * j) % 65536);
      e.idx  = 16'(j);
      e.last = (j == n - 1);
      exp_q.push_back(e);
    end
    bus.vec_ready = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = 16'(base);
    bus.num_vec   = 16'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_addr",  bus.mem_addr,  16'(base));
    chk("start_busy",  bus.busy,      1'b1);
    chk("start_valid", bus.vec_valid, 1'b0);
    @(negedge clk);
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      case (mode)
        0:       rdy = 1'b1;
        2:       rdy = (cyc >= 4);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      bus.vec_ready = rdy;
      if (cyc == ghost_at) begin
        bus.start     = 1'b1;
        bus.base_addr = 16'd64;
        bus.num_vec   = 16'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (prev_hold) begin
        chk("hold_vec",  bus.vec_out,  pv);
        chk("hold_idx",  bus.vec_idx,  pidx);
        chk("hold_last", bus.vec_last, plast);
        chk("hold_addr", bus.mem_addr, paddr);
      end
      if (mode == 0) chk("valid_seq", bus.vec_valid, (cyc < int'(n)));
      chk("addr_track", bus.mem_addr,
          16'((base + LANES * (popped + (bus.vec_valid ? 1 : 0))) % 65536));
      if (bus.done) begin
        got_done = 1;
        chk("done_lat", cyc, last_xfer + 1);
      end
      if (bus.vec_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_vec", bus.vec_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("vec_out",  bus.vec_out,  e.v);
          chk("vec_idx",  bus.vec_idx,  e.idx);
          chk("vec_last", bus.vec_last, e.last);
          popped++;
          last_xfer = cyc;
        end
      end
      prev_hold = bus.vec_valid && !rdy;
      pv    = bus.vec_out;
      pidx  = bus.vec_idx;
      plast = bus.vec_last;
      paddr = bus.mem_addr;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("got_done",   got_done,      1'b1);
    chk("vec_count",  popped,        n);
    chk("post_done",  bus.done,      1'b0);
    chk("post_busy",  bus.busy,      1'b0);
    chk("post_valid", bus.vec_valid, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_vec   = '0;
    bus.vec_ready = 1'b0;
    for (int k = 0; k < 65536; k++) mem[k] = 8'(k);

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst, back-pressure, end of image
    run_burst(0, 3, 0, -1);
    run_burst(16, 2, 2, -1);
    run_burst(9212, 1, 0, -1);

    // Empty burst: done pulse only
    bus.start   = 1'b1;
    bus.num_vec = 16'd0;
    bus.base_addr = 16'd100;
    @(negedge clk);
    bus.start = 1'b0;
    chk("nv0_done",  bus.done,      1'b1);
    chk("nv0_valid", bus.vec_valid, 1'b0);
    chk("nv0_busy",  bus.busy,      1'b0);
    @(negedge clk);
    chk("nv0_done_end", bus.done,      1'b0);
    chk("nv0_busy_end", bus.busy,      1'b0);
    chk("nv0_valid_end", bus.vec_valid, 1'b0);

    // Reset mid-burst
    bus.vec_ready = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = 16'd200;
    bus.num_vec   = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_valid", bus.vec_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_nodone",  bus.done,      1'b0);
      chk("midrst_novalid", bus.vec_valid, 1'b0);
    end
    run_burst(8, 1, 0, -1);

    // Start while busy is ignored
    run_burst(32, 6, 0, 2);

    // Randomized bursts over random memory contents, incl. address wrap
    for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
    run_burst(65528, 3, 1, 1);
    for (int t = 0; t < 10; t++) begin
      int unsigned b;
      int unsigned n;
      b = ($urandom_range(0, 1) != 0) ? $urandom_range(9150, 9230) : $urandom_range(0, 65535);
      n = $urandom_range(1, 12);
      run_burst(b, n, 1, $urandom_range(0, 1) != 0 ? int'($urandom_range(0, n - 1)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
